// File: rtl/ps2_kb_pkg.sv
// Shared constants and types for the PS/2 keyboard event receiver:
// prefix codes, frame FSM states and the packed event word layout.
package ps2_kb_pkg;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    // Event word: {ext, brk, code[7:0]}
    localparam int unsigned EVT_W        = 10;
    localparam int unsigned EVT_EXT      = 9;
    localparam int unsigned EVT_BRK      = 8;
    localparam int unsigned EVT_CODE_LSB = 0;

    typedef logic [EVT_W-1:0] evt_t;

    function automatic evt_t make_evt(input logic ext, input logic brk, input logic [7:0] code);
        evt_t e;
        e                       = '0;
        e[EVT_EXT]              = ext;
        e[EVT_BRK]              = brk;
        e[EVT_CODE_LSB +: 8]    = code;
        return e;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock deglitch filter, 11-bit
// frame FSM with odd-parity/stop checking and a stalled-transfer timeout.
module ps2_frame_rx
    import ps2_kb_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] byte_out,
    output logic       byte_stb,
    output logic       err_stb
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_LIMIT = TCW'(TIMEOUT_CYC);

    logic           c_meta, c_sync, d_meta, d_sync;
    logic           filt;
    logic [FCW-1:0] fcnt;
    logic           fall;
    logic [TCW-1:0] tmo_q;

    frame_state_t   state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic           byte_stb_d, err_stb_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            c_meta <= 1'b1;
            c_sync <= 1'b1;
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            c_meta <= ps2c;
            c_sync <= c_meta;
            d_meta <= ps2d;
            d_sync <= d_meta;
        end
    end

    // The filtered level follows only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 1'b1;
            fcnt <= '0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (c_sync == filt) begin
                fcnt <= '0;
            end else if (fcnt == FILT_LAST) begin
                filt <= c_sync;
                fcnt <= '0;
                fall <= filt;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || fall || state_q == ST_IDLE) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            byte_stb  <= 1'b0;
            err_stb   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            byte_stb  <= byte_stb_d;
            err_stb   <= err_stb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_stb_d = 1'b0;
        err_stb_d  = 1'b0;
        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!d_sync) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d = {d_sync, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_d   = d_sync;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if ((^{shift_q, par_q}) && d_sync) begin
                        byte_stb_d = 1'b1;
                    end else begin
                        err_stb_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_LIMIT) begin
            err_stb_d = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    assign byte_out = shift_q;

endmodule

// File: rtl/ps2_kb_event_rx.sv
// PS/2 keyboard event receiver: frame receiver, E0/F0 prefix decoder and a
// first-word fall-through event FIFO with a sticky overflow flag.
module ps2_kb_event_rx
    import ps2_kb_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rd_en,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [7:0]     byte_out;
    logic           byte_stb, err_stb;
    logic           ext_p, brk_p;
    logic           push, pop, wr_ok, empty, full;
    evt_t           push_evt, head;
    evt_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2c     (ps2c),
        .ps2d     (ps2d),
        .byte_out (byte_out),
        .byte_stb (byte_stb),
        .err_stb  (err_stb)
    );

    assign frame_err = err_stb;

    always_comb begin
        push     = byte_stb && (byte_out != CODE_EXT) && (byte_out != CODE_BRK);
        push_evt = make_evt(ext_p, brk_p, byte_out);
    end

    always_ff @(posedge clk) begin
        if (reset || err_stb) begin
            ext_p <= 1'b0;
            brk_p <= 1'b0;
        end else if (byte_stb) begin
            if (byte_out == CODE_EXT) begin
                ext_p <= 1'b1;
            end else if (byte_out == CODE_BRK) begin
                brk_p <= 1'b1;
            end else begin
                ext_p <= 1'b0;
                brk_p <= 1'b0;
            end
        end
    end

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = rd_en && !empty;
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign key_valid = !empty;
    assign key_code  = empty ? '0 : head[EVT_CODE_LSB +: 8];
    assign key_ext   = empty ? 1'b0 : head[EVT_EXT];
    assign key_brk   = empty ? 1'b0 : head[EVT_BRK];

endmodule

// File: tb/tb_ps2_kb_event_rx.sv
// Self-checking bench for ps2_kb_event_rx: bit-level PS/2 frame driver and a
// queue-based model of the prefix decoder and event FIFO.
module tb_ps2_kb_event_rx;

    localparam int FL    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 2000;
    localparam int HP    = 40;

    logic       clk = 1'b0;
    logic       reset, ps2c, ps2d, rd_en;
    logic       key_valid, key_ext, key_brk, frame_err, overflow;
    logic [7:0] key_code;

    int n_chk = 0;
    int n_fail = 0;
    int err_cnt = 0;
    int wide_cnt = 0;
    bit err_prev = 1'b0;

    bit         ext_m, brk_m, ovf_m;
    logic [9:0] exp_q[$];

    ps2_kb_event_rx #(
        .FILTER_LEN  (FL),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .rd_en     (rd_en),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_brk   (key_brk),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            err_cnt++;
            if (err_prev) wide_cnt++;
        end
        err_prev = (frame_err === 1'b1);
    end

    initial begin
        #(4_000_000);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    // Drives nbits of an 11-bit frame; optional short clock glitch during the
    // high phase of glitch_bit, optional rd_en pulse in the cycle the event is written.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int hp,
                              input int nbits, input int glitch_bit, input bit pop_at_stop);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (i == glitch_bit) begin
                cyc(hp / 2);
                ps2c = 1'b0;
                cyc(FL - 3);
                ps2c = 1'b1;
                cyc(hp - hp / 2 - (FL - 3));
            end else begin
                cyc(hp);
            end
            ps2c = 1'b0;
            if (pop_at_stop && i == 10) begin
                cyc(2 + FL + 1);
                rd_en = 1'b1;
                cyc(1);
                rd_en = 1'b0;
                cyc(hp - (2 + FL + 2));
            end else begin
                cyc(hp);
            end
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        cyc(hp);
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok, input bit pop_now);
        if (pop_now && exp_q.size() > 0) void'(exp_q.pop_front());
        if (!ok) begin
            ext_m = 1'b0;
            brk_m = 1'b0;
        end else if (b == 8'hE0) begin
            ext_m = 1'b1;
        end else if (b == 8'hF0) begin
            brk_m = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({ext_m, brk_m, b});
            else ovf_m = 1'b1;
            ext_m = 1'b0;
            brk_m = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit pop_now);
        send_frame(b, bad_par, HP, 11, -1, pop_now);
        model_frame(b, !bad_par, pop_now);
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rd_en = 1'b0;
        ext_m = 1'b0; brk_m = 1'b0; ovf_m = 1'b0;
        cyc(5);
        reset = 1'b0;
        cyc(1);
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        n_chk++; if (key_code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h want 00", key_code); end
        n_chk++; if (key_ext !== 1'b0) begin n_fail++; $display("FAIL reset_ext: got %b want 0", key_ext); end
        n_chk++; if (key_brk !== 1'b0) begin n_fail++; $display("FAIL reset_brk: got %b want 0", key_brk); end
        n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_single_key();
        int e0;
        e0 = err_cnt;
        send_frame(8'h45, 1'b0, 250, 11, -1, 1'b0);
        model_frame(8'h45, 1'b1, 1'b0);
        n_chk++; if (key_valid !== 1'b1 || key_code !== 8'h45 || key_ext !== 1'b0 || key_brk !== 1'b0) begin
            n_fail++; $display("FAIL single_head: got v=%b code=%h ext=%b brk=%b want v=1 code=45 ext=0 brk=0",
                                key_valid, key_code, key_ext, key_brk);
        end
        pop_one();
        void'(exp_q.pop_front());
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got valid=%b want 0", key_valid); end
        n_chk++; if (err_cnt != e0) begin n_fail++; $display("FAIL single_err: got %0d errors want 0", err_cnt - e0); end
    endtask

    task automatic test_prefixes();
        frame(8'hF0, 1'b0, 1'b0);
        frame(8'h45, 1'b0, 1'b0);
        n_chk++; if (exp_q.size() != 1 || exp_q[0] !== 10'h145) begin n_fail++; $display("FAIL brk_model: size=%0d", exp_q.size()); end
        while (exp_q.size() > 0) begin
            n_chk++; if (key_valid !== 1'b1 || {key_ext, key_brk, key_code} !== exp_q[0]) begin
                n_fail++; $display("FAIL brk_head: got v=%b %h want v=1 %h", key_valid, {key_ext, key_brk, key_code}, exp_q[0]);
            end
            pop_one(); void'(exp_q.pop_front());
        end
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL brk_empty: got valid=%b want 0", key_valid); end
        frame(8'hF0, 1'b0, 1'b0);
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL prefix_only: got valid=%b want 0", key_valid); end
        frame(8'hE0, 1'b0, 1'b0);
        frame(8'hF0, 1'b0, 1'b0);
        frame(8'h75, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            n_chk++; if (key_valid !== 1'b1 || {key_ext, key_brk, key_code} !== exp_q[0]) begin
                n_fail++; $display("FAIL ext_brk_head: got v=%b %h want v=1 %h", key_valid, {key_ext, key_brk, key_code}, exp_q[0]);
            end
            pop_one(); void'(exp_q.pop_front());
        end
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ext_brk_empty: got valid=%b want 0", key_valid); end
    endtask

    task automatic test_parity();
        int e0;
        e0 = err_cnt;
        frame(8'hF0, 1'b0, 1'b0);
        frame(8'h45, 1'b1, 1'b0);
        n_chk++; if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL parity_err: got %0d pulses want 1", err_cnt - e0); end
        n_chk++; if (wide_cnt != 0) begin n_fail++; $display("FAIL parity_width: got %0d extra cycles want 0", wide_cnt); end
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL parity_noentry: got valid=%b want 0", key_valid); end
        frame(8'h45, 1'b0, 1'b0);
        n_chk++; if (key_valid !== 1'b1 || key_code !== 8'h45 || key_brk !== 1'b0 || key_ext !== 1'b0) begin
            n_fail++; $display("FAIL parity_recover: got v=%b code=%h ext=%b brk=%b want v=1 code=45 ext=0 brk=0",
                                key_valid, key_code, key_ext, key_brk);
        end
        pop_one(); void'(exp_q.pop_front());
    endtask

    task automatic test_empty_pushpop();
        frame(8'h29, 1'b0, 1'b1);
        n_chk++; if (key_valid !== 1'b1 || {key_ext, key_brk, key_code} !== 10'h029) begin
            n_fail++; $display("FAIL empty_pushpop: got v=%b %h want v=1 029", key_valid, {key_ext, key_brk, key_code});
        end
        pop_one(); void'(exp_q.pop_front());
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        logic [7:0] refill [4];
        codes  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        refill = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
        for (int i = 0; i < 5; i++) begin
            frame(codes[i], 1'b0, 1'b0);
            if (i == 3) begin
                n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
            end
        end
        n_chk++; if (overflow !== ovf_m) begin n_fail++; $display("FAIL ovf_set: got %b want %b", overflow, ovf_m); end
        while (exp_q.size() > 0) begin
            n_chk++; if (key_valid !== 1'b1 || {key_ext, key_brk, key_code} !== exp_q[0]) begin
                n_fail++; $display("FAIL ovf_order: got v=%b %h want v=1 %h", key_valid, {key_ext, key_brk, key_code}, exp_q[0]);
            end
            pop_one(); void'(exp_q.pop_front());
        end
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got valid=%b want 0", key_valid); end
        for (int i = 0; i < 4; i++) frame(refill[i], 1'b0, 1'b0);
        frame(8'h36, 1'b0, 1'b1);
        n_chk++; if (overflow !== ovf_m) begin n_fail++; $display("FAIL ovf_pushpop: got %b want %b", overflow, ovf_m); end
        n_chk++; if (exp_q.size() != DEPTH || exp_q[DEPTH-1] !== 10'h036) begin
            n_fail++; $display("FAIL ovf_model: size=%0d", exp_q.size());
        end
        while (exp_q.size() > 0) begin
            n_chk++; if (key_valid !== 1'b1 || {key_ext, key_brk, key_code} !== exp_q[0]) begin
                n_fail++; $display("FAIL full_pushpop: got v=%b %h want v=1 %h", key_valid, {key_ext, key_brk, key_code}, exp_q[0]);
            end
            pop_one(); void'(exp_q.pop_front());
        end
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got valid=%b want 0", key_valid); end
    endtask

    task automatic test_timeout();
        int e0;
        frame(8'hF0, 1'b0, 1'b0);
        e0 = err_cnt;
        send_frame(8'h5A, 1'b0, HP, 6, -1, 1'b0);
        n_chk++; if (err_cnt != e0) begin n_fail++; $display("FAIL tmo_early: got %0d pulses want 0", err_cnt - e0); end
        cyc(TMO + 300);
        model_frame(8'h00, 1'b0, 1'b0);
        n_chk++; if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL tmo_err: got %0d pulses want 1", err_cnt - e0); end
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_noentry: got valid=%b want 0", key_valid); end
        frame(8'h16, 1'b0, 1'b0);
        n_chk++; if (key_valid !== 1'b1 || {key_ext, key_brk, key_code} !== exp_q[0]) begin
            n_fail++; $display("FAIL tmo_recover: got v=%b %h want v=1 %h", key_valid, {key_ext, key_brk, key_code}, exp_q[0]);
        end
        pop_one(); void'(exp_q.pop_front());
        n_chk++; if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL tmo_after: got %0d pulses want 1", err_cnt - e0); end
    endtask

    task automatic test_reset_midframe();
        int e0;
        frame(8'h1A, 1'b0, 1'b0);
        e0 = err_cnt;
        send_frame(8'h45, 1'b0, HP, 4, -1, 1'b0);
        reset = 1'b1;
        cyc(3);
        n_chk++; if ({key_valid, key_code, key_ext, key_brk, frame_err, overflow} !== 13'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %b want all 0",
                                {key_valid, key_code, key_ext, key_brk, frame_err, overflow});
        end
        reset = 1'b0;
        exp_q.delete(); ext_m = 1'b0; brk_m = 1'b0; ovf_m = 1'b0;
        cyc(TMO + 100);
        n_chk++; if (err_cnt != e0) begin n_fail++; $display("FAIL midreset_err: got %0d pulses want 0", err_cnt - e0); end
        frame(8'h45, 1'b0, 1'b0);
        n_chk++; if (key_valid !== 1'b1 || {key_ext, key_brk, key_code} !== 10'h045) begin
            n_fail++; $display("FAIL midreset_recover: got v=%b %h want v=1 045", key_valid, {key_ext, key_brk, key_code});
        end
        pop_one(); void'(exp_q.pop_front());
    endtask

    task automatic test_glitch();
        int e0;
        e0 = err_cnt;
        ps2d = 1'b0;
        cyc(20);
        ps2c = 1'b0;
        cyc(FL - 3);
        ps2c = 1'b1;
        cyc(20);
        ps2d = 1'b1;
        cyc(40);
        send_frame(8'h45, 1'b0, HP, 11, 3, 1'b0);
        model_frame(8'h45, 1'b1, 1'b0);
        n_chk++; if (err_cnt != e0) begin n_fail++; $display("FAIL glitch_err: got %0d pulses want 0", err_cnt - e0); end
        n_chk++; if (key_valid !== 1'b1 || {key_ext, key_brk, key_code} !== exp_q[0]) begin
            n_fail++; $display("FAIL glitch_code: got v=%b %h want v=1 %h", key_valid, {key_ext, key_brk, key_code}, exp_q[0]);
        end
        pop_one(); void'(exp_q.pop_front());
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_extra: got valid=%b want 0", key_valid); end
    endtask

    task automatic test_random();
        int e0, err_m, r, hp;
        logic [7:0] b;
        bit bad;
        e0 = err_cnt;
        err_m = 0;
        for (int n = 0; n < 14; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else begin
                b = 8'($urandom);
                if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
            end
            bad = ($urandom_range(0, 9) == 0);
            hp = $urandom_range(30, 60);
            send_frame(b, bad, hp, 11, -1, 1'b0);
            model_frame(b, !bad, 1'b0);
            if (bad) err_m++;
            n_chk++; if (err_cnt != e0 + err_m) begin n_fail++; $display("FAIL rand_err: got %0d pulses want %0d", err_cnt - e0, err_m); end
            if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) begin
                n_chk++; if (key_valid !== 1'b1 || {key_ext, key_brk, key_code} !== exp_q[0]) begin
                    n_fail++; $display("FAIL rand_head: got v=%b %h want v=1 %h", key_valid, {key_ext, key_brk, key_code}, exp_q[0]);
                end
                pop_one(); void'(exp_q.pop_front());
            end
        end
        n_chk++; if (overflow !== ovf_m) begin n_fail++; $display("FAIL rand_ovf: got %b want %b", overflow, ovf_m); end
        while (exp_q.size() > 0) begin
            n_chk++; if (key_valid !== 1'b1 || {key_ext, key_brk, key_code} !== exp_q[0]) begin
                n_fail++; $display("FAIL rand_drain: got v=%b %h want v=1 %h", key_valid, {key_ext, key_brk, key_code}, exp_q[0]);
            end
            pop_one(); void'(exp_q.pop_front());
        end
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rand_empty: got valid=%b want 0", key_valid); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_prefixes();
        test_parity();
        test_empty_pushpop();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        test_glitch();
        test_random();
        n_chk++; if (wide_cnt != 0) begin n_fail++; $display("FAIL err_width: got %0d extra cycles want 0", wide_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kb_event_rx.md
# ps2_kb_event_rx

PS/2 keyboard receiver with a deglitched clock, a frame checker, make/break/extended prefix decoding and a parametrised event FIFO. It sits between the raw `ps2c`/`ps2d` pins and the scan-code-to-ASCII/UART path. It replaces the bare byte receiver with one that rejects bad frames, recovers from stalled transfers, and buffers complete key events.

## Interface
- `FILTER_LEN`, 8: consecutive equal `ps2c` samples required to change the filtered clock level.
- `FIFO_DEPTH`, 4: event FIFO entries; must be a power of two, at least 2.
- `TIMEOUT_CYC`, 50000: clk cycles without a filtered falling edge before an open frame is aborted (1 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock, 50 MHz nominal.
- `reset`  in  1  synchronous, active-high.
- `ps2c`  in  1  PS/2 clock pin, asynchronous.
- `ps2d`  in  1  PS/2 data pin, asynchronous.
- `rd_en`  in  1  pops the FIFO head; ignored when `key_valid`=0.
- `key_valid`  out  1  FIFO not empty.
- `key_code`  out  8  head scan code (first-word fall-through).
- `key_ext`  out  1  head event was prefixed by E0.
- `key_brk`  out  1  head event was prefixed by F0 (key release).
- `frame_err`  out  1  one-cycle pulse on a start, parity, stop or timeout error.
- `overflow`  out  1  sticky flag, set when an event is dropped on full; cleared only by `reset`.

## Operation
- Input conditioning: `ps2c` and `ps2d` each pass through a 2-FF synchroniser. The filtered clock level changes only after `FILTER_LEN` consecutive agreeing synchronised samples. A filtered 1→0 transition produces a one-cycle `fall` strobe, and the synchronised `ps2d` is sampled on that strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data 0, go to DATA. A start bit of 1 is ignored and raises no error.
  - DATA: shift 8 bits in, LSB first. After bit 7, go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: the frame is valid if the parity is odd over data+parity and the stop bit is 1. Otherwise pulse `frame_err`. Always return to IDLE.
- Timeout: a counter clears on every `fall` and counts while the FSM is not IDLE. When it reaches `TIMEOUT_CYC`, pulse `frame_err`, discard the partial byte and return to IDLE.
- Prefix decoder: holds two pending flags, `ext_p` and `brk_p`.
  - Valid byte E0: set `ext_p`.
  - Valid byte F0: set `brk_p`.
  - Any other valid byte: push {`ext_p`, `brk_p`, byte} and clear both flags.
  - Any `frame_err`: clear both flags.
  - Prefixes never create FIFO entries.
- FIFO:
  - Push when full: the event is dropped, `overflow` is set, and contents are unchanged.
  - Push and pop in the same cycle when full: both are performed and no overflow occurs.
  - Push and pop in the same cycle when empty: only the push takes effect.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- Reset values: all outputs 0. FSM in IDLE, FIFO empty, pending flags clear, filter state 1 (line idle).
- Reset asserted mid-frame abandons the frame silently, with no `frame_err`.

## Timing
- `ps2c` pin edge to `fall` strobe: 2 synchroniser cycles + `FILTER_LEN` cycles.
- Stop-bit `fall` in cycle E:
  - `frame_err` (if any) and decoder update in cycle E+1.
  - FIFO write at the E+1 clock edge.
  - `key_valid` and head fields visible in cycle E+2.
- Pop: `rd_en`=1 with `key_valid`=1 in cycle P advances the head. The new head or `key_valid`=0 appears in P+1.
- `frame_err` is exactly one cycle wide per error event.

## Structure
- Package `ps2_kb_pkg` holds:
  - the E0/F0 constants,
  - the frame FSM state encoding,
  - the event word width (10 bits: ext, brk, code[7:0]) and its field positions.
- Sub-module `ps2_frame_rx` contains the synchronisers, filter, frame FSM and timeout. Its outputs are `byte_out[7:0]`, `byte_stb` and `err_stb`.
- The prefix decoder and FIFO live in the top level.

## Test plan
- **Single key:** PS/2 clock half-period 5 µs, frame 0x45 (data 1,0,1,0,0,0,1,0, parity 0, stop 1) → `key_valid`=1, `key_code`=0x45, `key_ext`=0, `key_brk`=0. One-cycle `rd_en` → `key_valid`=0 the next cycle.
- **Break and extended prefixes:**
  - Frames F0, 45 → exactly one entry: 0x45, `key_brk`=1. F0 alone leaves `key_valid`=0.
  - Frames E0, F0, 75 → one entry: 0x75, `key_ext`=1, `key_brk`=1.
- **Parity error:** F0, then 0x45 with parity bit 1 → one-cycle `frame_err`, no entry. A following good 0x45 gives `key_brk`=0 because the pending flag was cleared.
- **Overflow:** `FIFO_DEPTH`+1 codes 0x16, 0x1E, 0x26, 0x25, 0x2E with no reads → first four read back in order, 0x2E lost, `overflow`=1. Refill to full, then push 0x36 while pulsing `rd_en` → accepted, `overflow` unchanged.
- **Timeout and reset:**
  - Stop `ps2c` after 5 data bits for longer than `TIMEOUT_CYC` cycles → `frame_err` pulse. The next full frame 0x16 is received correctly.
  - `reset` asserted mid-frame → all outputs 0, no `frame_err`. A following 0x45 frame is received correctly.
- **Glitch rejection:** a `ps2c` low glitch shorter than `FILTER_LEN` cycles during IDLE and during DATA → no bit shift and no error. The 0x45 frame is still decoded correctly.
